eq_cmp_arbiter: RTL and testbench



---
 rtl/eq_cmp_arbiter_pkg.sv | 10 +
 rtl/eq_cmp_arbiter_eq_cell.sv | 13 +
 rtl/eq_cmp_arbiter_rr_pick.sv | 34 +++
 rtl/eq_cmp_arbiter.sv | 103 ++++++++++
 tb/tb_eq_cmp_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_cmp_arbiter_pkg.sv
// Shared defaults for the equality-comparator arbiter: requester count,
// operand and ID widths, and the match counter width.
package eq_cmp_arbiter_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 12;
   localparam int IDW_DEF  = 2;
   localparam int CNT_W    = 16;

endpackage

// File: rtl/eq_cmp_arbiter_eq_cell.sv
// W-bit equality cell; the arbiter instantiates exactly one of these and
// time-shares it among all requesters.
module eq_cell #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq
);

   assign eq = (a == b);

endmodule

// File: rtl/eq_cmp_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set bit of req found
// searching upward from ptr with wrap-around.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            any
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the search loop so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      // NOTE: blocking assignments here: 'any' must update immediately so
      // later loop iterations see that a grant was already made.
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eq_cmp_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared W-bit
// equality comparator, with backpressure and a saturating match counter.
module eq_cmp_arbiter
   import eq_cmp_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_eq,
   output logic              rsp_neq,
   output logic [CNT_W-1:0]  match_cnt,
   input  logic              cnt_clr
);

   logic            s1_vld;
   logic [IDW-1:0]  s1_id;
   logic [W-1:0]    s1_a;
   logic [W-1:0]    s1_b;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            any;
   logic            s2_free;
   logic            s1_free;
   logic            accept;
   logic            cmp_eq;

   assign s2_free   = !rsp_valid || rsp_ready;
   assign s1_free   = !s1_vld || s2_free;
   // Gated by reset_n so nothing is accepted while reset is held.
   assign accept    = s1_free && any && reset_n;
   assign req_ready = accept ? gnt : '0;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   eq_cell #(.W(W)) u_eq (
      .a  (s1_a),
      .b  (s1_b),
      .eq (cmp_eq)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld    <= 1'b0;
         s1_id     <= '0;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_eq    <= 1'b0;
         rsp_neq   <= 1'b0;
      end else begin
         if (accept) begin
            s1_vld <= 1'b1;
            s1_id  <= gnt_id;
            ptr    <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
         end else if (s2_free) begin
            s1_vld <= 1'b0;
         end
         if (s2_free) begin
            rsp_valid <= s1_vld;
            rsp_id    <= s1_id;
            rsp_eq    <= s1_vld && cmp_eq;
            rsp_neq   <= s1_vld && !cmp_eq;
         end
      end
   end

   // NOTE: operand registers are left without reset; s1_vld qualifies them,
   // so their power-up contents are never observed.
   always_ff @(posedge clock) begin
      if (accept) begin
         s1_a <= req_a[int'(gnt_id)*W +: W];
         s1_b <= req_b[int'(gnt_id)*W +: W];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (rsp_valid && rsp_ready && rsp_eq && (match_cnt != '1)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Randomized bench for eq_cmp_arbiter: a transaction-level model predicts
// grants and occupancy, a scoreboard queue carries expected responses.
module tb_eq_cmp_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 12;
   localparam int IDW  = 2;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_eq;
   logic              rsp_neq;
   logic [15:0]       match_cnt;
   logic              cnt_clr;

   eq_cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_eq    (rsp_eq),
      .rsp_neq   (rsp_neq),
      .match_cnt (match_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clock = ~clock;

   typedef struct {
      int id;
      bit eq;
   } exp_t;

   exp_t sb[$];
   bit   inflight_eq[$];

   int errors = 0;
   int checks = 0;

   // Model state: a pipe of at most two transactions and a rotating priority.
   bit              m_s1;
   bit              m_s2;
   int              m_ptr;
   int              m_cnt;
   logic [NREQ-1:0] acc_vec = '0;
   int              preload_seq = 0;
   int              seen_seq = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: samples just before each rising edge.
   initial begin
      forever begin
         @(negedge clock);
         #4;
         if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_ptr = 0; m_cnt = 0;
            sb.delete();
            inflight_eq.delete();
            acc_vec = '0;
            check("reset_rsp_valid", 32'(rsp_valid), 0);
            check("reset_req_ready", 32'(req_ready), 0);
            check("reset_match_cnt", 32'(match_cnt), 0);
         end else begin
            bit s2f, s1f;
            int gid;
            logic [NREQ-1:0] er;
            bit popped_eq;
            if (preload_seq != seen_seq) begin
               m_cnt    = 16'hFFFE;
               seen_seq = preload_seq;
            end
            s2f = !m_s2 || rsp_ready;
            s1f = !m_s1 || s2f;
            gid = -1;
            er  = '0;
            if (s1f) begin
               for (int k = 0; k < NREQ; k++) begin
                  int j;
                  j = (m_ptr + k) % NREQ;
                  if (gid < 0 && req_valid[j]) gid = j;
               end
            end
            if (gid >= 0) er[gid] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            check("rsp_valid", 32'(rsp_valid), 32'(m_s2));
            check("match_cnt", 32'(match_cnt), 32'(m_cnt));
            acc_vec = er;
            if (gid >= 0) begin
               exp_t e;
               e.id = gid;
               e.eq = (req_a[gid*W +: W] == req_b[gid*W +: W]);
               sb.push_back(e);
               inflight_eq.push_back(e.eq);
            end
            popped_eq = 0;
            if (m_s2 && rsp_ready && inflight_eq.size() > 0) popped_eq = inflight_eq.pop_front();
            if (cnt_clr) m_cnt = 0;
            else if (popped_eq && m_cnt < 16'hFFFF) m_cnt++;
            if (s2f) m_s2 = m_s1;
            if (gid >= 0) begin
               m_s1  = 1;
               m_ptr = (gid + 1) % NREQ;
            end else if (s2f) begin
               m_s1 = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever a response handshake occurs.
   initial begin
      forever begin
         @(negedge clock);
         #4;
         if (reset_n) begin
            if (rsp_valid) check("rsp_onehot", 32'(rsp_eq ^ rsp_neq), 1);
            else           check("rsp_idle", 32'({rsp_eq, rsp_neq}), 0);
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", 32'(rsp_valid), 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("rsp_id", 32'(rsp_id), 32'(e.id));
                  check("rsp_eq", 32'(rsp_eq), 32'(e.eq));
                  check("rsp_neq", 32'(rsp_neq), 32'(!e.eq));
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clock);
      req_valid = req_valid & ~acc_vec;
   endtask

   task automatic present(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!req_valid[i]) begin
         req_valid[i]     = 1'b1;
         req_a[i*W +: W]  = a;
         req_b[i*W +: W]  = b;
      end
   endtask

   task automatic present_rand(input int i);
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 1) == 1) ? a : W'($urandom);
      present(i, a, b);
   endtask

   task automatic drain();
      bit idle;
      rsp_ready = 1'b1;
      cnt_clr   = 1'b0;
      idle      = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (req_valid == '0 && sb.size() == 0 && !rsp_valid) begin
            idle = 1;
            break;
         end
      end
      check("drain_idle", 32'(idle), 1);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      cnt_clr   = 1'b0;
      #3;
      check("por_rsp_valid", 32'(rsp_valid), 0);
      check("por_match_cnt", 32'(match_cnt), 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // Single request from requester 2.
      tick();
      present(2, 12'h5A3, 12'h5A3);
      repeat (4) tick();
      check("single_match_cnt", 32'(match_cnt), 1);

      // Round-robin with all requesters continuously valid.
      for (int c = 0; c < 12; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++) present_rand(i);
      end
      drain();

      // Backpressure: park requester 0 first so the pointer sits at 1.
      present(0, 12'h123, 12'h124);
      drain();
      rsp_ready = 1'b0;
      present_rand(1);
      present_rand(3);
      repeat (5) tick();
      #3;
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_id", 32'(rsp_id), 1);
      drain();

      // Operand boundary cases.
      tick(); present(0, 12'hFFF, 12'h7FF);
      tick(); present(0, 12'h000, 12'h000);
      tick(); present(0, 12'h001, 12'h000);
      tick(); present(0, 12'hFFF, 12'hFFF);
      drain();

      // Counter saturation, then clear colliding with a match.
      tick();
      force dut.match_cnt = 16'hFFFE;
      #1;
      release dut.match_cnt;
      preload_seq++;
      for (int c = 0; c < 3; c++) begin
         tick();
         present(0, 12'hABC, 12'hABC);
      end
      drain();
      check("sat_match_cnt", 32'(match_cnt), 32'hFFFF);
      present(1, 12'h055, 12'h055);
      tick();
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      tick();
      check("clr_match_cnt", 32'(match_cnt), 0);
      drain();

      // Randomized traffic with random backpressure and clears.
      for (int c = 0; c < 400; c++) begin
         tick();
         rsp_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 2) == 0) present_rand(i);
      end
      drain();

      // Asynchronous reset with both stages occupied.
      present(2, 12'h00F, 12'h00F);
      drain();
      rsp_ready = 1'b0;
      tick();
      for (int i = 0; i < NREQ; i++) present_rand(i);
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rsp_valid", 32'(rsp_valid), 0);
      check("async_req_ready", 32'(req_ready), 0);
      check("async_match_cnt", 32'(match_cnt), 0);
      tick();
      tick();
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) present_rand(i);
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      #3;
      check("post_reset_grant", 32'(req_ready), 32'h1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
